// File: rtl/uart_frame_tx_pkg.sv
// Shared frame definitions: state encoding, default head byte and width helpers.
// The TX producer and the companion RX frame parser both import this package.
package uart_frame_tx_pkg;

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_HEAD = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_DONE = 3'd5
  } frame_state_e;

  localparam logic [7:0] FRAME_HEAD_DEFAULT = 8'hA5;

  function automatic int buf_addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so a completely full buffer (count == max_len) is representable.
  function automatic int count_width(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/uart_frame_tx_sync_ram_buf.sv
// Payload buffer: one write port, one registered read port, single clock.
module sync_ram_buf
  import uart_frame_tx_pkg::*;
#(
  parameter  int P_DEPTH = 16,
  parameter  int P_WIDTH = 8,
  localparam int AW      = buf_addr_width(P_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [P_WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]      i_rd_addr,
  output logic [P_WIDTH-1:0] o_rd_data
);

  logic [P_WIDTH-1:0] r_mem [P_DEPTH];
  logic [P_WIDTH-1:0] r_rd_data;

  // NOTE: storage has no reset; every slot is written in LOAD before DATA reads it.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/uart_frame_tx.sv
// Buffers one payload and emits it to the UART TX port as HEAD, LEN, payload..., CHK.
// CHK is the XOR of LEN and every payload byte; all TX outputs come straight from registers.
module uart_frame_tx
  import uart_frame_tx_pkg::*;
#(
  parameter int                      P_DATA_WIDTH = 8,
  parameter int                      P_MAX_LEN    = 16,
  parameter logic [P_DATA_WIDTH-1:0] P_HEAD       = P_DATA_WIDTH'(FRAME_HEAD_DEFAULT)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [P_DATA_WIDTH-1:0] i_payload_data,
  input  logic                    i_payload_valid,
  input  logic                    i_payload_last,
  output logic                    o_payload_ready,
  output logic [P_DATA_WIDTH-1:0] o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_busy,
  output logic                    o_frame_done
);

  localparam int            CW        = count_width(P_MAX_LEN);
  localparam int            AW        = buf_addr_width(P_MAX_LEN);
  localparam logic [CW-1:0] MAX_COUNT = CW'(P_MAX_LEN);

  frame_state_e            r_state;
  frame_state_e            w_state_next;
  logic [CW-1:0]           r_count;
  logic [CW-1:0]           w_count_next;
  logic [CW-1:0]           w_count_inc;
  logic [CW-1:0]           r_rd;
  logic [CW-1:0]           w_rd_next;
  logic [CW-1:0]           w_rd_inc;
  logic [P_DATA_WIDTH-1:0] r_chk;
  logic [P_DATA_WIDTH-1:0] w_chk_next;
  logic [P_DATA_WIDTH-1:0] r_tx_data;
  logic [P_DATA_WIDTH-1:0] w_tx_data_next;
  logic                    r_tx_valid;
  logic                    w_tx_valid_next;
  logic                    w_payload_ready;
  logic                    w_payload_xfer;
  logic                    w_tx_xfer;
  logic [AW-1:0]           w_rd_addr;
  logic [P_DATA_WIDTH-1:0] w_rd_data;

  assign w_payload_ready = (r_state == ST_LOAD);
  assign w_payload_xfer  = i_payload_valid && w_payload_ready;
  assign w_tx_xfer       = r_tx_valid && i_tx_ready;
  assign w_count_inc     = r_count + CW'(1);
  assign w_rd_inc        = r_rd + CW'(1);

  // The buffer output always holds buf[rd]; stepping the address on a transfer
  // keeps the following byte one cycle ahead of the output register.
  assign w_rd_addr = (w_tx_xfer && (r_state == ST_LEN || r_state == ST_DATA))
                   ? w_rd_inc[AW-1:0] : r_rd[AW-1:0];

  sync_ram_buf #(
    .P_DEPTH (P_MAX_LEN),
    .P_WIDTH (P_DATA_WIDTH)
  ) u_buf (
    .i_clk     (i_clk),
    .i_wr_en   (w_payload_xfer),
    .i_wr_addr (r_count[AW-1:0]),
    .i_wr_data (i_payload_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_rd_next       = r_rd;
    w_chk_next      = r_chk;
    w_tx_data_next  = r_tx_data;
    w_tx_valid_next = r_tx_valid;
    unique case (r_state)
      ST_LOAD: begin
        if (w_payload_xfer) begin
          w_count_next = w_count_inc;
          w_chk_next   = r_chk ^ i_payload_data;
          if (i_payload_last || (w_count_inc == MAX_COUNT)) begin
            w_state_next    = ST_HEAD;
            w_tx_valid_next = 1'b1;
            w_tx_data_next  = P_HEAD;
          end
        end
      end
      ST_HEAD: begin
        if (w_tx_xfer) begin
          w_state_next   = ST_LEN;
          w_tx_data_next = P_DATA_WIDTH'(r_count);
        end
      end
      ST_LEN: begin
        if (w_tx_xfer) begin
          w_state_next   = ST_DATA;
          w_tx_data_next = w_rd_data;
          w_rd_next      = w_rd_inc;
        end
      end
      ST_DATA: begin
        if (w_tx_xfer) begin
          // rd runs one ahead of the byte on the wire, so rd == count marks the final byte.
          if (r_rd == r_count) begin
            w_state_next   = ST_CHK;
            w_tx_data_next = r_chk ^ P_DATA_WIDTH'(r_count);
          end else begin
            w_tx_data_next = w_rd_data;
            w_rd_next      = w_rd_inc;
          end
        end
      end
      ST_CHK: begin
        if (w_tx_xfer) begin
          w_state_next    = ST_DONE;
          w_tx_valid_next = 1'b0;
          w_tx_data_next  = '0;
        end
      end
      ST_DONE: begin
        w_state_next = ST_LOAD;
        w_count_next = '0;
        w_rd_next    = '0;
        w_chk_next   = '0;
      end
      default: begin
        w_state_next    = ST_LOAD;
        w_count_next    = '0;
        w_rd_next       = '0;
        w_chk_next      = '0;
        w_tx_valid_next = 1'b0;
        w_tx_data_next  = '0;
      end
    endcase
  end

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count    <= '0;
      r_rd       <= '0;
      r_chk      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_count    <= w_count_next;
      r_rd       <= w_rd_next;
      r_chk      <= w_chk_next;
      r_tx_data  <= w_tx_data_next;
      r_tx_valid <= w_tx_valid_next;
    end
  end

  assign o_payload_ready = w_payload_ready;
  assign o_tx_data       = r_tx_data;
  assign o_tx_valid      = r_tx_valid;
  assign o_busy          = (r_state != ST_LOAD) || (r_count != '0);
  assign o_frame_done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: the payload model builds whole expected frames
// into a byte queue; an independent monitor pops and compares every accepted TX byte.
module tb_uart_frame_tx;

  localparam int         W       = 8;
  localparam int         MAX_LEN = 16;
  localparam logic [7:0] HEAD    = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       pay_last;
  logic       pay_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       frame_done;

  always #5 clk = ~clk;

  uart_frame_tx #(
    .P_DATA_WIDTH (W),
    .P_MAX_LEN    (MAX_LEN),
    .P_HEAD       (HEAD)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_payload_data  (pay_data),
    .i_payload_valid (pay_valid),
    .i_payload_last  (pay_last),
    .o_payload_ready (pay_ready),
    .o_tx_data       (tx_data),
    .o_tx_valid      (tx_valid),
    .i_tx_ready      (tx_ready),
    .o_busy          (busy),
    .o_frame_done    (frame_done)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         tx_cyc_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] model_buf[$];
  logic       prev_stall = 1'b0;
  logic       prev_done = 1'b0;
  logic [7:0] prev_data = '0;
  int         pos = 0;
  int         fr_len = 0;
  logic [7:0] fr_xor = '0;
  bit         stop_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: collect accepted payload bytes; a frame closes on last or when full.
  task automatic model_accept(input logic [7:0] d, input logic last);
    logic [7:0] x;
    model_buf.push_back(d);
    if (last || model_buf.size() == MAX_LEN) begin
      x = 8'(model_buf.size());
      exp_q.push_back(HEAD);
      exp_q.push_back(x);
      foreach (model_buf[i]) begin
        exp_q.push_back(model_buf[i]);
        x = x ^ model_buf[i];
      end
      exp_q.push_back(x);
      model_buf.delete();
    end
  endtask

  // Monitor: compares every TX transfer, checks stall stability and frame integrity.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
      pos        = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, prev_data);
      end
      if (frame_done) begin
        done_cnt++;
        check("done_width", {prev_done, frame_done}, 2'b01);
      end
      if (tx_valid && tx_ready) begin
        tx_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) check("tx_unexpected", tx_data, 32'hFFFF_FFFF);
        else check("tx_byte", tx_data, exp_q.pop_front());
        if (pos == 0) begin
          check("frame_head", tx_data, HEAD);
          pos = 1;
        end else if (pos == 1) begin
          fr_len = int'(tx_data);
          fr_xor = tx_data;
          check("frame_len_nonzero", tx_data != 8'h00, 1);
          pos = 2;
        end else begin
          fr_xor = fr_xor ^ tx_data;
          if (pos == fr_len + 2) begin
            check("frame_xor_zero", fr_xor, 0);
            pos = 0;
          end else begin
            pos++;
          end
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_done  = frame_done;
    end
  end

  // Offers one byte until accepted; returns at posedge+1 after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic last, output int acc_cyc);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    acc_cyc = 0;
    pay_data  = d;
    pay_last  = last;
    pay_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = pay_ready;
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    pay_valid = 1'b0;
    pay_last  = 1'b0;
    if (!acc) check("payload_accept_timeout", acc, 1);
    else model_accept(d, last);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("frames_done", done_cnt, target);
  endtask

  task automatic wait_tx_byte(input logic [7:0] d);
    int n;
    n = 0;
    while (!(tx_valid && tx_data == d) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_tx_byte_seen", {tx_valid, tx_data}, {1'b1, d});
  endtask

  initial begin
    int  c;
    int  c_last;
    int  base;
    int  base_tx;
    int  n;
    bit  seen;
    int  len;
    bit  force_end;
    int  gap;

    rst = 1'b1;
    pay_data = '0;
    pay_valid = 1'b0;
    pay_last = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_payload_ready", pay_ready, 1);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    @(posedge clk);
    #1;

    // 1: three-byte frame, back-to-back on the TX side
    base = done_cnt;
    base_tx = tx_cyc_q.size();
    send_byte(8'h11, 1'b0, c);
    check("t1_busy_loading", busy, 1);
    send_byte(8'h22, 1'b0, c);
    send_byte(8'h33, 1'b1, c_last);
    wait_done(base + 1);
    check("t1_tx_count", tx_cyc_q.size() - base_tx, 6);
    if (tx_cyc_q.size() >= base_tx + 6) begin
      check("t1_latency", tx_cyc_q[base_tx] - c_last, 1);
      check("t1_back_to_back", tx_cyc_q[base_tx + 5] - tx_cyc_q[base_tx], 5);
    end

    // 2: single byte; payload ready stays low from HEAD through DONE
    base = done_cnt;
    send_byte(8'hFF, 1'b1, c);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      check("t2_ready_low", pay_ready, 0);
      check("t2_busy_high", busy, 1);
      seen = frame_done;
      n++;
    end
    check("t2_done_seen", seen, 1);
    check("t2_cycles_head_to_done", n, 5);
    @(negedge clk);
    check("t2_ready_back", pay_ready, 1);
    check("t2_busy_idle", busy, 0);
    @(posedge clk);
    #1;
    check("t2_frames", done_cnt, base + 1);

    // 3: full buffer forces the end; the 17th byte waits for LOAD
    base = done_cnt;
    for (int i = 0; i < MAX_LEN; i++) send_byte(8'(i), 1'b0, c_last);
    send_byte(8'h77, 1'b1, c);
    check("t3_17th_pending", c - c_last, MAX_LEN + 5);
    wait_done(base + 2);

    // 4: TX stall for five cycles while DATA 22 is presented
    base = done_cnt;
    send_byte(8'h11, 1'b0, c);
    send_byte(8'h22, 1'b0, c);
    send_byte(8'h33, 1'b1, c);
    wait_tx_byte(8'h22);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_stall_data", tx_data, 8'h22);
      check("t4_stall_valid", tx_valid, 1);
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    wait_done(base + 1);

    // 5: reset mid-DATA discards the frame; the next frame is clean
    base = done_cnt;
    send_byte(8'h10, 1'b0, c);
    send_byte(8'h20, 1'b0, c);
    send_byte(8'h30, 1'b1, c);
    wait_tx_byte(8'h20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    model_buf.delete();
    @(negedge clk);
    check("t5_valid_after_rst", tx_valid, 0);
    check("t5_ready_after_rst", pay_ready, 1);
    check("t5_busy_after_rst", busy, 0);
    @(posedge clk);
    #1;
    check("t5_no_done", done_cnt, base);
    send_byte(8'h44, 1'b1, c);
    wait_done(base + 1);

    // 6: random payloads with random TX throttling
    base = done_cnt;
    fork
      begin
        while (!stop_rand) begin
          @(posedge clk);
          #1;
          tx_ready = ($urandom_range(0, 3) != 0);
        end
        tx_ready = 1'b1;
      end
    join_none
    for (int f = 0; f < 200; f++) begin
      len = int'($urandom_range(1, MAX_LEN));
      force_end = (len == MAX_LEN) && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < len; i++) begin
        gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        repeat (gap) begin
          pay_last = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        pay_last = 1'b0;
        send_byte(8'($urandom), (i == len - 1) && !force_end, c);
      end
    end
    wait_done(base + 200);
    stop_rand = 1'b1;
    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
